// File: rtl/apb_cfg_slv_pkg.sv
// Shared constants and types for the APB configuration slave: bus widths,
// address field positions and the transfer FSM state encoding.
package apb_cfg_slv_pkg;

  localparam int unsigned ApbAddrW     = 32;
  localparam int unsigned ApbDataW     = 32;
  localparam int unsigned EntryW       = 128;

  localparam int unsigned WordIdxLsb   = 2;
  localparam int unsigned WordIdxMsb   = 3;
  localparam int unsigned EntryIdxLsb  = 4;
  localparam int unsigned EntryIdxMsb  = 5;
  localparam int unsigned AddrValidLsb = 6;

  typedef enum logic [0:0] {
    StIdle,
    StAccess
  } state_e;

endpackage

// File: rtl/apb_cfg_slv.sv
// APB slave holding NUM_ENTRIES 128-bit configuration entries, written whole and
// read back one 32-bit word at a time, with a programmable number of wait states.
module apb_cfg_slv
  import apb_cfg_slv_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned NUM_ENTRIES = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          psel_i,
  input  logic                          penable_i,
  input  logic [ApbAddrW-1:0]           paddr_i,
  input  logic                          pwrite_i,
  input  logic [EntryW-1:0]             pwdata_i,
  output logic                          pready_o,
  output logic [ApbDataW-1:0]           prdata_o,
  output logic                          pslverr_o,
  output logic [NUM_ENTRIES*EntryW-1:0] cfg_data_o
);

  localparam logic [3:0] WaitMax = 4'(WAIT_CYCLES);

  state_e            state_q, state_d;
  logic [3:0]        wait_q, wait_d;
  logic [EntryW-1:0] entry_q [NUM_ENTRIES];

  logic [EntryIdxMsb-EntryIdxLsb:0] ent_idx;
  logic [WordIdxMsb-WordIdxLsb:0]   word_idx;
  logic                             addr_ok;
  logic                             xfer_done;
  logic                             entry_we;
  logic [EntryW-1:0]                sel_entry;
  logic [ApbDataW-1:0]              sel_word;
  logic                             unused_addr;

  assign ent_idx     = paddr_i[EntryIdxMsb:EntryIdxLsb];
  assign word_idx    = paddr_i[WordIdxMsb:WordIdxLsb];
  assign addr_ok     = (paddr_i[ApbAddrW-1:AddrValidLsb] == '0);
  assign unused_addr = ^paddr_i[WordIdxLsb-1:0];

  assign pready_o  = (state_q == StAccess) && (wait_q == WaitMax);
  assign xfer_done = psel_i && penable_i && pready_o;
  assign entry_we  = xfer_done && pwrite_i && addr_ok;

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    unique case (state_q)
      StIdle: begin
        if (psel_i && !penable_i) begin
          state_d = StAccess;
          wait_d  = '0;
        end
      end
      StAccess: begin
        // A dropped psel abandons the transfer without touching the entries.
        if (!psel_i || xfer_done) begin
          state_d = StIdle;
        end else if (wait_q < WaitMax) begin
          wait_d = wait_q + 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        entry_q[i] <= '0;
      end
    end else if (entry_we) begin
      entry_q[ent_idx] <= pwdata_i;
    end
  end

  always_comb begin
    sel_entry = entry_q[ent_idx];
    sel_word  = '0;
    unique case (word_idx)
      2'd0: sel_word = sel_entry[31:0];
      2'd1: sel_word = sel_entry[63:32];
      2'd2: sel_word = sel_entry[95:64];
      2'd3: sel_word = sel_entry[127:96];
      default: sel_word = '0;
    endcase
  end

  // Read data is only driven for a completing read to a decoded address.
  assign prdata_o  = (pready_o && addr_ok && !pwrite_i) ? sel_word : '0;
  assign pslverr_o = pready_o && !addr_ok;

  always_comb begin
    cfg_data_o = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      cfg_data_o[i*EntryW +: EntryW] = entry_q[i];
    end
  end

endmodule

// File: tb/tb_apb_cfg_slv.sv
// Scoreboard bench for apb_cfg_slv: three instances with 1, 0 and 3 wait states
// share one APB bus, each selected through its own psel.
module tb_apb_cfg_slv;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         psel, penable, pwrite;
  logic [31:0]  paddr;
  logic [127:0] pwdata;
  int           cur;

  logic         pready  [3];
  logic [31:0]  prdata  [3];
  logic         pslverr [3];
  logic [511:0] cfg     [3];
  logic [511:0] exp_cfg [3];

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    string       name;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   acc_cnt  = 0;

  localparam logic [127:0] P = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
  localparam logic [127:0] Q = 128'hDEAD_BEEF_CAFE_F00D_1357_9BDF_2468_ACE0;
  localparam logic [127:0] R = 128'hA5A5_0001_5A5A_0002_C3C3_0003_3C3C_0004;
  localparam logic [127:0] S = 128'hFFFF_EEEE_DDDD_CCCC_BBBB_AAAA_9999_8888;
  localparam logic [127:0] T = 128'h1111_2222_3333_4444_5555_6666_7777_8888;

  always #5 clk = ~clk;

  apb_cfg_slv #(.WAIT_CYCLES(1), .NUM_ENTRIES(4)) u_w1 (
    .clk(clk), .rst_n(rst_n), .psel_i(psel && cur == 0), .penable_i(penable),
    .paddr_i(paddr), .pwrite_i(pwrite), .pwdata_i(pwdata), .pready_o(pready[0]),
    .prdata_o(prdata[0]), .pslverr_o(pslverr[0]), .cfg_data_o(cfg[0])
  );

  apb_cfg_slv #(.WAIT_CYCLES(0), .NUM_ENTRIES(4)) u_w0 (
    .clk(clk), .rst_n(rst_n), .psel_i(psel && cur == 1), .penable_i(penable),
    .paddr_i(paddr), .pwrite_i(pwrite), .pwdata_i(pwdata), .pready_o(pready[1]),
    .prdata_o(prdata[1]), .pslverr_o(pslverr[1]), .cfg_data_o(cfg[1])
  );

  apb_cfg_slv #(.WAIT_CYCLES(3), .NUM_ENTRIES(4)) u_w3 (
    .clk(clk), .rst_n(rst_n), .psel_i(psel && cur == 2), .penable_i(penable),
    .paddr_i(paddr), .pwrite_i(pwrite), .pwdata_i(pwdata), .pready_o(pready[2]),
    .prdata_o(prdata[2]), .pslverr_o(pslverr[2]), .cfg_data_o(cfg[2])
  );

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: counts access cycles and pops the scoreboard on every pready.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (psel && penable) acc_cnt++;
        if (pready[cur]) begin
          if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_pready: dut %0d got pready=1 expected 0", cur);
          end else begin
            e = q.pop_front();
            chk({e.name, "_prdata"}, 512'(prdata[cur]), 512'(e.rdata));
            chk({e.name, "_pslverr"}, 512'(pslverr[cur]), 512'(e.err));
            chk({e.name, "_latency"}, 512'(acc_cnt), 512'(e.lat));
          end
          acc_cnt = 0;
        end else if (!psel) begin
          acc_cnt = 0;
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after completion with psel low,
  // so an immediate follow-up call is a back-to-back transfer.
  task automatic xfer(input int k, input logic [31:0] a, input logic w, input logic [127:0] d,
                      input logic [31:0] er, input logic ee, input int lat, input string name);
    int  n;
    bit  done;
    exp_t e;
    e.rdata = er; e.err = ee; e.lat = lat; e.name = name;
    q.push_back(e);
    cur = k; psel = 1'b1; penable = 1'b0; paddr = a; pwrite = w; pwdata = d;
    @(posedge clk); #1 penable = 1'b1;
    n = 0;
    done = 1'b0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
      if (pready[k]) done = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: got no pready in %0d cycles, expected pready", name, n);
      void'(q.pop_back());
    end
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation still running, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; cur = 0;
    for (int i = 0; i < 3; i++) exp_cfg[i] = '0;
    #3;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_pready%0d", i), 512'(pready[i]), 512'd0);
      chk($sformatf("rst_prdata%0d", i), 512'(prdata[i]), 512'd0);
      chk($sformatf("rst_pslverr%0d", i), 512'(pslverr[i]), 512'd0);
      chk($sformatf("rst_cfg%0d", i), cfg[i], 512'd0);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // One wait state: write, then word reads and a back-to-back read
    xfer(0, 32'h10, 1'b1, P, 32'h0, 1'b0, 2, "w1_wr10");
    exp_cfg[0][255:128] = P;
    chk("w1_cfg_after_wr", cfg[0], exp_cfg[0]);
    xfer(0, 32'h18, 1'b0, '0, 32'h89AB_CDEF, 1'b0, 2, "w1_rd18");
    xfer(0, 32'h1C, 1'b0, '0, 32'h0123_4567, 1'b0, 2, "w1_rd1c");
    xfer(0, 32'h13, 1'b0, '0, 32'h4455_6677, 1'b0, 2, "w1_rd13");

    // Out-of-range addresses error out and leave the entries alone
    xfer(0, 32'h40, 1'b1, '1, 32'h0, 1'b1, 2, "w1_wr40");
    chk("w1_cfg_after_badwr", cfg[0], exp_cfg[0]);
    xfer(0, 32'h40, 1'b0, '0, 32'h0, 1'b1, 2, "w1_rd40");
    xfer(0, 32'h8000_0010, 1'b0, '0, 32'h0, 1'b1, 2, "w1_rdhi");

    // Zero wait states
    xfer(1, 32'h00, 1'b1, Q, 32'h0, 1'b0, 1, "w0_wr00");
    xfer(1, 32'h00, 1'b0, '0, 32'h2468_ACE0, 1'b0, 1, "w0_rd00");
    xfer(1, 32'h34, 1'b1, P, 32'h0, 1'b0, 1, "w0_wr34");
    xfer(1, 32'h34, 1'b0, '0, 32'h0011_2233, 1'b0, 1, "w0_rd34");
    exp_cfg[1][127:0]   = Q;
    exp_cfg[1][511:384] = P;
    chk("w0_cfg", cfg[1], exp_cfg[1]);

    // Three wait states
    xfer(2, 32'h00, 1'b1, R, 32'h0, 1'b0, 4, "w3_wr00");
    xfer(2, 32'h00, 1'b0, '0, 32'h3C3C_0004, 1'b0, 4, "w3_rd00");
    xfer(2, 32'h0C, 1'b0, '0, 32'hA5A5_0001, 1'b0, 4, "w3_rd0c");
    exp_cfg[2][127:0] = R;

    // Aborted write: psel drops after one access cycle
    cur = 2; psel = 1'b1; penable = 1'b0; paddr = 32'h00; pwrite = 1'b1; pwdata = S;
    @(posedge clk); #1 penable = 1'b1;
    @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("abort_pready_c%0d", i), 512'(pready[2]), 512'd0);
    end
    chk("abort_cfg", cfg[2], exp_cfg[2]);
    @(posedge clk); #1;
    xfer(2, 32'h00, 1'b0, '0, 32'h3C3C_0004, 1'b0, 4, "abort_rd00");

    // Reset during the completing access cycle of a write to entry 2
    cur = 0; psel = 1'b1; penable = 1'b0; paddr = 32'h20; pwrite = 1'b1; pwdata = T;
    @(posedge clk); #1 penable = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_pready_pre", 512'(pready[0]), 512'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_pready", 512'(pready[0]), 512'd0);
    chk("rst_mid_prdata", 512'(prdata[0]), 512'd0);
    chk("rst_mid_pslverr", 512'(pslverr[0]), 512'd0);
    for (int i = 0; i < 3; i++) begin
      exp_cfg[i] = '0;
      chk($sformatf("rst_mid_cfg%0d", i), cfg[i], exp_cfg[i]);
    end
    psel = 1'b0; penable = 1'b0;
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_entry2", cfg[0][383:256], 512'd0);
    xfer(0, 32'h20, 1'b1, T, 32'h0, 1'b0, 2, "post_rst_wr20");
    exp_cfg[0][383:256] = T;
    chk("post_rst_cfg", cfg[0], exp_cfg[0]);
    xfer(0, 32'h24, 1'b0, '0, 32'h5555_6666, 1'b0, 2, "post_rst_rd24");

    repeat (2) @(posedge clk);
    chk("scoreboard_empty", 512'(q.size()), 512'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/apb_cfg_slv.md
APB_CFG_SLV -- requirements
Module: apb_cfg_slv

Interface
REQ-001 Parameter WAIT_CYCLES, default 1, number of access-phase cycles with pready low before completion (range 0..15).
REQ-002 Parameter NUM_ENTRIES, default 4, number of 128-bit configuration entries (fixed power of two, 4 in this release).
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 psel  input  1  APB select.
REQ-006 penable  input  1  APB access-phase enable.
REQ-007 paddr  input  32  byte address.
REQ-008 pwrite  input  1  1 = write, 0 = read.
REQ-009 pwdata  input  128  write data, full 128-bit entry.
REQ-010 pready  output  1  transfer completion.
REQ-011 prdata  output  32  read data word.
REQ-012 pslverr  output  1  transfer error.
REQ-013 cfg_data  output  512  concatenated entries, entry k at bits [128k+127:128k], for downstream logic.

Function
REQ-014 FSM states IDLE and ACCESS; wait counter wait_cnt 4 bits.
REQ-015 IDLE -> ACCESS when psel=1 and penable=0 sampled; wait_cnt cleared to 0.
REQ-016 In ACCESS, wait_cnt increments by 1 per cycle while wait_cnt < WAIT_CYCLES; saturates at WAIT_CYCLES.
REQ-017 pready = 1 exactly when state=ACCESS and wait_cnt=WAIT_CYCLES; otherwise 0 (WAIT_CYCLES=0 gives zero-wait completion in the first access cycle).
REQ-018 ACCESS -> IDLE at the edge where psel=1, penable=1, pready=1 (transfer completes).
REQ-019 ACCESS -> IDLE with no side effect if psel=0 sampled (aborted transfer); no register update, no error.
REQ-020 Address decode: entry index = paddr[5:4], word index = paddr[3:2], paddr[1:0] ignored; address valid only when paddr[31:6]=0.
REQ-021 Write completion with valid address: entry[paddr[5:4]] <= pwdata (all 128 bits) at the completing edge; cfg_data reflects it the next cycle.
REQ-022 Read with valid address: prdata = 32-bit word paddr[3:2] of entry paddr[5:4] while pready=1; prdata = 0 whenever pready=0.
REQ-023 Invalid address: pslverr=1 while pready=1; writes discarded; prdata = 0.
REQ-024 pslverr = 0 whenever pready=0.
REQ-025 Back-to-back: a new setup phase in the cycle after completion is accepted; no idle cycle required between transfers.
REQ-026 A read and write to the same entry in consecutive transfers: read returns the newly written value.

Reset
REQ-027 rst_n=0 asynchronously forces state=IDLE, wait_cnt=0, all entries=0, pready=0, prdata=0, pslverr=0, cfg_data=0.
REQ-028 Reset asserted mid-transfer aborts it; no entry update; slave ready for a new setup phase after rst_n deasserts.

Structure
REQ-029 FSM state enum, APB address/data width constants, and entry-address field positions belong in the shared parameters package.
REQ-030 Single module; the entry storage array is the only natural sub-block and stays inline (no separate sub-module).

Verification
REQ-031 Write paddr=0x10, pwdata=0x0123_4567_89AB_CDEF_0011_2233_4455_6677, WAIT_CYCLES=1 -> pready high in 2nd access cycle, pslverr=0, cfg_data[255:128] equals pwdata next cycle.
REQ-032 Read paddr=0x18 after REQ-031 -> prdata=0x89AB_CDEF, pslverr=0; paddr=0x1C -> prdata=0x0123_4567.
REQ-033 Write paddr=0x40, pwdata=all-ones -> pslverr=1 with pready, cfg_data unchanged; read paddr=0x40 -> prdata=0, pslverr=1.
REQ-034 WAIT_CYCLES=0 vs 3: pready rises in access cycle 1 vs 4; back-to-back write then read of paddr=0x00 returns written word [31:0].
REQ-035 Setup then psel dropped before completion -> FSM back to IDLE, no write, pready never asserted.
REQ-036 rst_n pulsed low during ACCESS of a write to 0x20 -> all outputs 0 immediately, entry 2 stays 0, next transfer completes normally.
